// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_sequencer
// Brief    : Feeds (a,b,d) terms and OPMODE to a DSP48A1 slice and captures the
//            accumulated sum of (d+b)*a once the slice pipeline has drained.
// Revision : 1.0  initial release
// ============================================================================
module dsp_mac_sequencer #(
    parameter int N_TAPS   = 16,
    parameter int PIPE_LAT = 4,
    parameter int OPM_DLY  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] in_a,
    input  logic [17:0] in_b,
    input  logic [17:0] in_d,
    input  logic        in_last,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [17:0] dsp_d,
    output logic [7:0]  dsp_opmode,
    input  logic [47:0] dsp_p,
    input  logic        dsp_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] out_p,
    output logic        out_ovf,
    output logic        out_trunc,
    output logic        busy
);

    localparam int c_CNT_W = $clog2(N_TAPS + 1);
    localparam int c_DRN_W = $clog2(PIPE_LAT + 1);
    localparam logic [7:0] c_OPM_FIRST  = 8'b0001_0001;
    localparam logic [7:0] c_OPM_NEXT   = 8'b0001_1001;
    localparam logic [7:0] c_OPM_BUBBLE = 8'b0000_1000;
    localparam logic [c_CNT_W-1:0] c_TAPS_MAX  = c_CNT_W'(N_TAPS);
    localparam logic [c_DRN_W-1:0] c_DRAIN_END = c_DRN_W'(PIPE_LAT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [c_CNT_W-1:0] tap_cnt_q, tap_cnt_d;
    logic [c_DRN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic               last_seen_q, last_seen_d;
    logic [17:0]        opa_q, opa_d, opb_q, opb_d, opd_q, opd_d;
    logic [7:0]         opm_pipe_q [0:OPM_DLY];
    logic [7:0]         opm_pipe_d [0:OPM_DLY];
    logic               out_valid_q, out_valid_d;
    logic [47:0]        out_p_q, out_p_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_trunc_q, out_trunc_d;

    logic               w_accept;
    logic               w_capture;
    logic [7:0]         w_slot;
    logic [c_CNT_W-1:0] w_tap_inc;

    assign in_ready   = (state_q != S_DRAIN);
    assign busy       = (state_q != S_IDLE);
    assign w_accept   = in_valid && in_ready;
    assign w_tap_inc  = tap_cnt_q + c_CNT_W'(1);
    // P is frozen by bubbles, so a blocked capture simply waits for the consumer.
    assign w_capture  = (state_q == S_DRAIN) && (drain_cnt_q == c_DRAIN_END) &&
                        (!out_valid_q || out_ready);

    always_comb begin
        state_d     = state_q;
        tap_cnt_d   = tap_cnt_q;
        drain_cnt_d = drain_cnt_q;
        last_seen_d = last_seen_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        opd_d       = opd_q;
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
        out_ovf_d   = out_ovf_q;
        out_trunc_d = out_trunc_q;
        w_slot      = c_OPM_BUBBLE;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (w_accept) begin
            opa_d = in_a;
            opb_d = in_b;
            opd_d = in_d;
        end

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    w_slot      = c_OPM_FIRST;
                    tap_cnt_d   = c_CNT_W'(1);
                    last_seen_d = in_last;
                    drain_cnt_d = '0;
                    state_d     = (in_last || (N_TAPS == 1)) ? S_DRAIN : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept) begin
                    w_slot      = c_OPM_NEXT;
                    tap_cnt_d   = w_tap_inc;
                    last_seen_d = in_last;
                    drain_cnt_d = '0;
                    if (in_last || (w_tap_inc == c_TAPS_MAX)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_capture) begin
                    out_p_d     = dsp_p;
                    out_ovf_d   = dsp_cout;
                    out_trunc_d = (tap_cnt_q == c_TAPS_MAX) && !last_seen_q;
                    out_valid_d = 1'b1;
                    tap_cnt_d   = '0;
                    last_seen_d = 1'b0;
                    drain_cnt_d = '0;
                    state_d     = S_IDLE;
                end else if (drain_cnt_q != c_DRAIN_END) begin
                    drain_cnt_d = drain_cnt_q + c_DRN_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stage 0 is aligned with the operand registers; the last stage drives the slice.
    always_comb begin
        opm_pipe_d[0] = w_slot;
        for (int i = 1; i <= OPM_DLY; i++) begin
            opm_pipe_d[i] = opm_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tap_cnt_q   <= '0;
            drain_cnt_q <= '0;
            last_seen_q <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            opd_q       <= '0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_ovf_q   <= 1'b0;
            out_trunc_q <= 1'b0;
            for (int i = 0; i <= OPM_DLY; i++) begin
                opm_pipe_q[i] <= c_OPM_BUBBLE;
            end
        end else begin
            state_q     <= state_d;
            tap_cnt_q   <= tap_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            last_seen_q <= last_seen_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            opd_q       <= opd_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
            out_ovf_q   <= out_ovf_d;
            out_trunc_q <= out_trunc_d;
            for (int i = 0; i <= OPM_DLY; i++) begin
                opm_pipe_q[i] <= opm_pipe_d[i];
            end
        end
    end

    assign dsp_a      = opa_q;
    assign dsp_b      = opb_q;
    assign dsp_d      = opd_q;
    assign dsp_opmode = opm_pipe_q[OPM_DLY];
    assign out_valid  = out_valid_q;
    assign out_p      = out_p_q;
    assign out_ovf    = out_ovf_q;
    assign out_trunc  = out_trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp_mac_sequencer
// Brief    : Sequencer coupled to a small DSP48A1 behavioural model; results
//            are checked against a queue of hand-computed job sums.
// Revision : 1.0  initial release
// ============================================================================
module tb_dsp_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last;
    logic [17:0] in_a, in_b, in_d;
    logic [17:0] dsp_a, dsp_b, dsp_d;
    logic [7:0]  dsp_opmode;
    logic [47:0] dsp_p;
    logic        dsp_cout;
    logic        out_valid, out_ready;
    logic [47:0] out_p;
    logic        out_ovf, out_trunc, busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [47:0] p;
        logic        ovf;
        logic        trunc;
    } res_t;
    res_t exp_q[$];
    res_t mon_e;

    always #5 clk = ~clk;

    dsp_mac_sequencer #(.N_TAPS(4), .PIPE_LAT(4), .OPM_DLY(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_d(in_d), .in_last(in_last),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_opmode(dsp_opmode),
        .dsp_p(dsp_p), .dsp_cout(dsp_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_ovf(out_ovf), .out_trunc(out_trunc), .busy(busy)
    );

    // Slice model: A1/B1/D -> M -> P with a registered OPMODE; not reset by rst_n.
    logic signed [17:0] m_pre;
    logic signed [35:0] m_prod;
    logic [47:0]        m1, m2, m3, p_r, m_x, m_z;
    logic [7:0]         opm_r;
    logic               cout_r;

    initial begin
        m1 = '0; m2 = '0; m3 = '0; p_r = '0; opm_r = 8'h08; cout_r = 1'b0;
    end

    always_comb begin
        m_pre  = $signed(dsp_d) + $signed(dsp_b);
        m_prod = m_pre * $signed(dsp_a);
        m_x    = (opm_r[1:0] == 2'b01) ? m3 : 48'd0;
        m_z    = (opm_r[3:2] == 2'b10) ? p_r : 48'd0;
    end

    always @(posedge clk) begin
        m1    <= {{12{m_prod[35]}}, m_prod};
        m2    <= m1;
        m3    <= m2;
        opm_r <= dsp_opmode;
        {cout_r, p_r} <= {1'b0, m_z} + {1'b0, m_x};
    end

    assign dsp_p    = p_r;
    assign dsp_cout = cout_r;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every consumed result must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got 0x%0h expected none", out_p);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_p", out_p, mon_e.p);
                check("result_ovf", {47'd0, out_ovf}, {47'd0, mon_e.ovf});
                check("result_trunc", {47'd0, out_trunc}, {47'd0, mon_e.trunc});
            end
        end
    end

    task automatic send(input logic [17:0] a, input logic [17:0] b,
                        input logic [17:0] d, input logic last);
        int n;
        in_valid = 1'b1;
        in_a = a; in_b = b; in_d = d; in_last = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push(input logic [47:0] p, input logic trunc);
        res_t r;
        r.p = p; r.ovf = 1'b0; r.trunc = trunc;
        exp_q.push_back(r);
    endtask

    task automatic basic_job(input int gap);
        send(18'd2, 18'd3, 18'd4, 1'b0);
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        send(18'd10, 18'd10, 18'd25, 1'b0);
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        send(18'd1, 18'd0, 18'd1, 1'b1);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'($urandom);
        in_last   = 1'($urandom);
        in_a      = 18'($urandom);
        in_b      = 18'($urandom);
        in_d      = 18'($urandom);
        out_ready = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check("rst_dsp_a", {30'd0, dsp_a}, 48'd0);
        check("rst_dsp_b", {30'd0, dsp_b}, 48'd0);
        check("rst_dsp_d", {30'd0, dsp_d}, 48'd0);
        check("rst_opmode", {40'd0, dsp_opmode}, 48'h08);
        check("rst_out_valid", {47'd0, out_valid}, 48'd0);
        check("rst_out_p", out_p, 48'd0);
        check("rst_out_ovf", {47'd0, out_ovf}, 48'd0);
        check("rst_out_trunc", {47'd0, out_trunc}, 48'd0);
        check("rst_busy", {47'd0, busy}, 48'd0);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", {47'd0, in_ready}, 48'd1);
        check("rel_busy", {47'd0, busy}, 48'd0);

        // Basic back-to-back job with exact capture latency.
        push(48'h16D, 1'b0);
        basic_job(0);
        check("lat_e0", {47'd0, out_valid}, 48'd0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("lat_e%0d", k), {47'd0, out_valid}, (k == 5) ? 48'd1 : 48'd0);
        end
        repeat (3) @(posedge clk);
        #1;

        // Idle gaps inside the job insert bubbles only.
        push(48'h16D, 1'b0);
        basic_job(2);
        repeat (8) @(posedge clk);
        #1;

        // Backpressure: second job waits in DRAIN behind an unconsumed result.
        out_ready = 1'b0;
        push(48'h16D, 1'b0);
        basic_job(0);
        push(48'h9B, 1'b0);
        send(18'd5, 18'd6, 18'd25, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("bp_held_p", out_p, 48'h16D);
        check("bp_held_valid", {47'd0, out_valid}, 48'd1);
        check("bp_in_ready", {47'd0, in_ready}, 48'd0);
        check("bp_busy", {47'd0, busy}, 48'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_swap_p", out_p, 48'h9B);
        check("bp_swap_valid", {47'd0, out_valid}, 48'd1);
        repeat (3) @(posedge clk);
        #1;

        // Truncation at N_TAPS=4; the fifth term opens a new job.
        push(48'h8, 1'b1);
        repeat (4) send(18'd1, 18'd1, 18'd1, 1'b0);
        push(48'h4, 1'b0);
        send(18'd1, 18'd1, 18'd1, 1'b0);
        check("trunc_new_job_accum", {46'd0, in_ready, busy}, 48'd3);
        send(18'd1, 18'd1, 18'd1, 1'b1);
        repeat (8) @(posedge clk);
        #1;

        // Exactly N_TAPS terms with in_last on the final one is not truncation.
        push(48'h24, 1'b0);
        repeat (3) send(18'd3, 18'd1, 18'd2, 1'b0);
        send(18'd3, 18'd1, 18'd2, 1'b1);
        repeat (10) @(posedge clk);
        #1;

        // Mid-job reset discards the partial sum.
        send(18'd7, 18'd7, 18'd7, 1'b0);
        send(18'd7, 18'd7, 18'd7, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", {47'd0, busy}, 48'd0);
        check("midrst_opmode", {40'd0, dsp_opmode}, 48'h08);
        check("midrst_dsp_a", {30'd0, dsp_a}, 48'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(48'h16D, 1'b0);
        basic_job(0);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            @(posedge clk);
        end
        #1;
        check("queue_drained", 48'(exp_q.size()), 48'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Upstream operand and control sequencer for the DSP48A1 slice. It accepts a stream of (a, b, d) terms over a valid/ready handshake and drives the slice's A/B/D operand ports and OPMODE so that the slice computes sum over k of (d_k + b_k) * a_k. It tracks the slice's fixed pipeline latency and captures the final P value into a held output register with its own valid/ready handshake. It is the first consumer-facing stage of the MAC datapath and feeds the DSP slice directly.

## Interface
- N_TAPS, 16: max terms per job; a job is forcibly ended on term N_TAPS.
- PIPE_LAT, 4: edges from dsp_a/b/d presentation to that term's effect appearing on dsp_p.
- OPM_DLY, 2: edges between a term's operands appearing on dsp_a/b/d and its opmode appearing on dsp_opmode.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  term offered.
- in_ready  out  1  term accepted when in_valid && in_ready at a rising edge.
- in_a, in_b, in_d  in  18 each  term operands.
- in_last  in  1  marks the final term of a job.
- dsp_a, dsp_b, dsp_d  out  18 each  registered operands to the slice.
- dsp_opmode  out  8  registered OPMODE to the slice.
- dsp_p  in  48  slice P output.
- dsp_cout  in  1  slice CARRYOUT.
- out_valid  out  1  result held.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_p  out  48  captured job sum.
- out_ovf  out  1  dsp_cout sampled with out_p.
- out_trunc  out  1  job ended by the N_TAPS limit, not by in_last.
- busy  out  1  state != IDLE.

## Operation
- States:
  - IDLE: in_ready=1. An accepted term issues as FIRST and moves to ACCUM, or to DRAIN if in_last is set.
  - ACCUM: in_ready=1. An accepted term issues as NEXT. In_last, or term count == N_TAPS, moves to DRAIN.
  - DRAIN: in_ready=0. Counts PIPE_LAT+1 edges, then captures.
- Every cycle issues one slot onto a PIPE_LAT-aligned opmode delay line of depth OPM_DLY:
  - FIRST: opmode 8'b00010001 (pre-add D+B, X=M, Z=0).
  - NEXT: 8'b00011001 (X=M, Z=P).
  - BUBBLE: 8'b00001000 (X=0, Z=P, so P holds). Issued on every cycle with no accepted term, including all DRAIN and IDLE cycles.
- Operand regs load only on accepted terms. They hold their value otherwise (their bubble slots use X=0, so stale data is harmless).
- Capture at the end of DRAIN: out_p<=dsp_p, out_ovf<=dsp_cout, out_trunc<=(term count == N_TAPS && !last seen), out_valid<=1. Then go to IDLE.
- Capture blocked: if out_valid && !out_ready at the capture edge, DRAIN stays and keeps issuing BUBBLE. P is stable, so capture happens at the first edge where out_ready is high or out_valid is low.
- Consumption (out_valid && out_ready): clears out_valid at that edge. A capture on the same edge wins (out_valid stays 1 with new data).
- Term counter: width clog2(N_TAPS+1). Set to 1 on FIRST, incremented on NEXT, cleared on capture.
- Arithmetic is done entirely by the slice. The block passes operand bits unmodified and adds no width handling.

## Timing
- Reset (rst_n low, any time): state IDLE, all counters 0, delay line filled with BUBBLE.
  - Outputs: in_ready=1 after release, dsp_a/b/d=0, dsp_opmode=8'h08, out_valid=0, out_p=0, out_ovf=0, out_trunc=0, busy=0.
  - A reset mid-job discards the job. The next FIRST clears P through Z=0.
- Last term accepted at edge e: dsp operands change after e. out_valid rises after edge e+PIPE_LAT+1 when unblocked.
- Throughput: one term per cycle within a job. Between jobs: PIPE_LAT+1 DRAIN cycles plus 1 IDLE cycle minimum.
- A single-term job (FIRST with in_last) follows the same latency.
- in_valid gaps inside ACCUM are legal. They insert bubbles and do not change the sum.

## Test plan
All scenarios couple the block to the team's DSP48A1 model, configured with A1/B1/D/M/P/OPMODE registers so that PIPE_LAT=4 and OPM_DLY=2.

- Reset: rst_n low with random inputs -> all outputs at the reset values above. Release -> in_ready=1, busy=0.
- Basic job: terms (a,b,d) = (2,3,4), (10,10,25), (1,0,1), last on the third, back-to-back, out_ready=1 -> out_p=0x16D, out_ovf=0, out_trunc=0. out_valid rises exactly 5 edges after the third accept.
- Gapped job: same terms with 2 idle cycles between each term -> out_p=0x16D.
- Backpressure: hold out_ready=0 and run a second job (5,6,25) last.
  - First result 0x16D stays stable on out_p; the second job waits in DRAIN with in_ready=0.
  - Raise out_ready -> out_p becomes 0x9B on the same edge, out_valid stays 1.
- Truncation: N_TAPS=4, feed 5 terms of (1,1,1) with no in_last -> first result 0x8 with out_trunc=1. The fifth term starts a new job.
- Mid-job reset: assert rst_n low after 2 terms, then run the basic job -> out_p=0x16D, with no residue from before the reset.
